// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU-level types: RAM handshake state, word type, and the RAM
//   arbiter's state encoding and debug counter width.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Returns the first active index at or
//   after i_ptr, scanning upward modulo NREQ.
//   Ports:
//     i_active  NREQ   requester active vector
//     i_ptr     IDX_W  round-robin start index
//     o_gnt     IDX_W  selected index (0 when nothing is active)
//     o_any     1      at least one requester is active
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_active,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_gnt,
  output logic             o_any
);

  int w_dist;
  int w_best;

  // Distance of each candidate from i_ptr (mod NREQ); the active candidate
  // with the smallest distance wins.
  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    o_gnt  = '0;
    o_any  = 1'b0;
    w_best = NREQ;
    w_dist = 0;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = j - int'(i_ptr);
      if (w_dist < 0) w_dist = w_dist + NREQ;
      if (i_active[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_gnt  = IDX_W'(j);
        o_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//   Shares the single RAM port between NREQ cache requesters, round-robin.
//   One transaction is held open until RAM reports ACCESS, followed by one
//   DRAIN cycle with enables low. tb_hold parks the arbiter in IDLE.
//   Ports:
//     CLK, RST            clock, synchronous active-high reset
//     req_ren/req_wen     per-requester read/write request
//     req_addr/req_store  per-requester address / write data
//     req_wait            per-requester stall (low = done this cycle)
//     req_load            read data, valid where req_wait is low
//     memREN/memWEN       RAM enables
//     memaddr/memstore    RAM address / write data
//     ramstate/ramload    RAM status / read data
//     tb_hold             testbench requests the port
//     tb_idle             arbiter parked in IDLE
// -----------------------------------------------------------------------------
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_ren,
  input  logic [NREQ-1:0]       req_wen,
  input  word_t [NREQ-1:0]      req_addr,
  input  word_t [NREQ-1:0]      req_store,
  output logic [NREQ-1:0]       req_wait,
  output word_t                 req_load,
  output logic                  memREN,
  output logic                  memWEN,
  output word_t                 memaddr,
  output word_t                 memstore,
  input  ramstate_t             ramstate,
  input  word_t                 ramload,
  input  logic                  tb_hold,
  output logic                  tb_idle
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  arb_state_t             r_state;
  arb_state_t             w_next_state;
  logic [IDX_W-1:0]       r_gnt;
  logic [IDX_W-1:0]       r_ptr;
  logic [ARB_CNT_W-1:0]   r_xfer_cnt;

  logic [NREQ-1:0]        w_active;
  logic [IDX_W-1:0]       w_pick;
  logic                   w_any;
  logic                   w_done;

  assign w_active = req_ren | req_wen;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_active (w_active),
    .i_ptr    (r_ptr),
    .o_gnt    (w_pick),
    .o_any    (w_any)
  );

  // Completion: granted requester still active and RAM reports ACCESS.
  assign w_done = (r_state == XFER) && w_active[r_gnt] && (ramstate == ACCESS);

  // Next-state logic. ERROR falls through like BUSY, so the request is retried.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!tb_hold && w_any) w_next_state = XFER;
      XFER:    if (!w_active[r_gnt]) w_next_state = IDLE;  // abandoned
               else if (ramstate == ACCESS) w_next_state = DRAIN;
      DRAIN:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs. Write wins when a requester raises both enables.
  always_comb begin
    memREN   = 1'b0;
    memWEN   = 1'b0;
    memaddr  = '0;
    memstore = '0;
    req_load = '0;
    req_wait = w_active;
    if (r_state == XFER) begin
      memWEN   = req_wen[r_gnt];
      memREN   = req_ren[r_gnt] & ~req_wen[r_gnt];
      memaddr  = req_addr[r_gnt];
      memstore = req_store[r_gnt];
    end
    if (w_done) begin
      req_wait[r_gnt] = 1'b0;
      req_load        = ramload;
    end
  end

  assign tb_idle = (r_state == IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_xfer_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && (w_next_state == XFER)) begin
        r_gnt      <= w_pick;
        r_xfer_cnt <= '0;
      end
      if (r_state == XFER) begin
        if (r_xfer_cnt != '1) r_xfer_cnt <= r_xfer_cnt + 1'b1;
        if (w_done) r_ptr <= (r_gnt == LAST_IDX) ? '0 : r_gnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//   Directed bench for ram_arbiter (NREQ = 2). RAM responses are driven by
//   hand each cycle; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 2;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req_ren;
  logic [NREQ-1:0]   req_wen;
  word_t [NREQ-1:0]  req_addr;
  word_t [NREQ-1:0]  req_store;
  logic [NREQ-1:0]   req_wait;
  word_t             req_load;
  logic              memREN;
  logic              memWEN;
  word_t             memaddr;
  word_t             memstore;
  ramstate_t         ramstate;
  word_t             ramload;
  logic              tb_hold;
  logic              tb_idle;

  int n_checks = 0;
  int n_pass   = 0;

  ram_arbiter #(.NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_store (req_store),
    .req_wait  (req_wait),
    .req_load  (req_load),
    .memREN    (memREN),
    .memWEN    (memWEN),
    .memaddr   (memaddr),
    .memstore  (memstore),
    .ramstate  (ramstate),
    .ramload   (ramload),
    .tb_hold   (tb_hold),
    .tb_idle   (tb_idle)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance one clock; inputs are then changed 2 time units after the edge
  // and outputs sampled 1 unit later, well away from the rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_wait;
    int g;

    RST = 1'b1; req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
    ramstate = FREE; ramload = '0; tb_hold = 1'b0;
    req_ren[0] = 1'b1; req_addr[0] = 32'h40;

    // ---- Reset with requester 0 reading 0x40 ----
    tick(); tick(); #1;
    check("rst_ren",  32'(memREN), 32'd0);
    check("rst_addr", memaddr, 32'd0);
    check("rst_wait", 32'(req_wait), 32'b01);
    check("rst_idle", 32'(tb_idle), 32'd1);
    check("rst_gnt",  32'(dut.r_gnt), 32'd0);
    check("rst_ptr",  32'(dut.r_ptr), 32'd0);
    check("rst_cnt",  32'(dut.r_xfer_cnt), 32'd0);

    RST = 1'b0;
    tick(); #1;                                   // XFER, gnt 0
    check("first_ren",  32'(memREN), 32'd1);
    check("first_wen",  32'(memWEN), 32'd0);
    check("first_addr", memaddr, 32'h40);
    check("first_wait", 32'(req_wait), 32'b01);
    check("first_busy_idle", 32'(tb_idle), 32'd0);
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    check("first_done_wait", 32'(req_wait), 32'b00);
    check("first_load", req_load, 32'hDEADBEEF);
    tick(); req_ren = '0; ramstate = FREE; #1;    // DRAIN
    check("first_drain_ren", 32'(memREN), 32'd0);
    check("first_drain_load", req_load, 32'd0);
    check("first_ptr", 32'(dut.r_ptr), 32'd1);
    tick(); #1;                                   // IDLE
    check("first_idle", 32'(tb_idle), 32'd1);

    // ---- Both requesting, RAM latency 2: grants alternate from ptr=1 ----
    req_ren = 2'b11; req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    for (int t = 0; t < 4; t++) begin
      g = (t % 2 == 0) ? 1 : 0;
      exp_addr = (g == 1) ? 32'h200 : 32'h100;
      exp_wait = (g == 1) ? 32'b01 : 32'b10;
      tick(); ramstate = BUSY; #1;
      check("rr_ren",  32'(memREN), 32'd1);
      check("rr_addr", memaddr, exp_addr);
      check("rr_wait", 32'(req_wait), 32'b11);
      tick(); ramstate = ACCESS; #1;
      check("rr_done_wait", 32'(req_wait), exp_wait);
      tick(); ramstate = FREE; #1;
      check("rr_drain_ren",  32'(memREN), 32'd0);
      check("rr_drain_wait", 32'(req_wait), 32'b11);
      tick(); #1;
      check("rr_idle", 32'(tb_idle), 32'd1);
      if (t == 3) req_ren = '0;
    end

    // ---- Requester 1: ren+wen to 0x80, store 0x1234 (ptr=1) ----
    req_ren = 2'b10; req_wen = 2'b10; req_addr[1] = 32'h80; req_store[1] = 32'h1234;
    tick(); ramstate = ACCESS; #1;
    check("wr_wen",   32'(memWEN), 32'd1);
    check("wr_ren",   32'(memREN), 32'd0);
    check("wr_store", memstore, 32'h1234);
    check("wr_addr",  memaddr, 32'h80);
    check("wr_wait",  32'(req_wait), 32'b00);
    tick(); req_ren = '0; req_wen = '0; ramstate = FREE; #1;
    check("wr_drain_wen",   32'(memWEN), 32'd0);
    check("wr_drain_store", memstore, 32'd0);
    check("wr_ptr", 32'(dut.r_ptr), 32'd0);
    tick();

    // ---- ERROR for 3 cycles then ACCESS ----
    req_ren[0] = 1'b1; req_addr[0] = 32'h44;
    tick(); ramstate = ERROR;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("err_ren",  32'(memREN), 32'd1);
      check("err_addr", memaddr, 32'h44);
      check("err_wait", 32'(req_wait), 32'b01);
      tick();
    end
    ramstate = ACCESS; #1;
    check("err_done_wait", 32'(req_wait), 32'b00);
    check("err_cnt", 32'(dut.r_xfer_cnt), 32'd3);
    check("err_ptr_hold", 32'(dut.r_ptr), 32'd0);
    tick(); req_ren = '0; ramstate = FREE; #1;
    check("err_ptr", 32'(dut.r_ptr), 32'd1);
    tick(); #1;
    check("err_ptr_once", 32'(dut.r_ptr), 32'd1);

    // ---- tb_hold rises mid-XFER ----
    req_ren[0] = 1'b1; req_addr[0] = 32'h90;
    tick(); ramstate = BUSY; tb_hold = 1'b1; #1;
    check("hold_ren",  32'(memREN), 32'd1);
    check("hold_addr", memaddr, 32'h90);
    check("hold_idle", 32'(tb_idle), 32'd0);
    tick(); #1;
    check("hold_still_ren", 32'(memREN), 32'd1);
    ramstate = ACCESS; #1;
    check("hold_done_wait", 32'(req_wait), 32'b00);
    tick(); req_ren = 2'b10; req_addr[1] = 32'h50; ramstate = FREE; #1;
    check("hold_drain_ren", 32'(memREN), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("hold_parked_idle", 32'(tb_idle), 32'd1);
      check("hold_parked_ren",  32'(memREN), 32'd0);
      check("hold_parked_wait", 32'(req_wait), 32'b10);
    end
    tb_hold = 1'b0;
    tick(); #1;                                   // XFER, gnt 1
    check("rel_ren",  32'(memREN), 32'd1);
    check("rel_addr", memaddr, 32'h50);

    // ---- RST pulsed mid-XFER (gnt=1, ptr=1 before) ----
    ramstate = BUSY;
    tick(); RST = 1'b1;
    tick(); #1;
    check("rstx_ren",  32'(memREN), 32'd0);
    check("rstx_gnt",  32'(dut.r_gnt), 32'd0);
    check("rstx_ptr",  32'(dut.r_ptr), 32'd0);
    check("rstx_wait", 32'(req_wait), 32'b10);
    tick(); #1;
    check("rstx_hold_ren", 32'(memREN), 32'd0);
    RST = 1'b0;
    tick(); #1;                                   // regranted
    check("regrant_ren",  32'(memREN), 32'd1);
    check("regrant_addr", memaddr, 32'h50);
    check("regrant_gnt",  32'(dut.r_gnt), 32'd1);
    ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    check("regrant_wait", 32'(req_wait), 32'b00);
    check("regrant_load", req_load, 32'hCAFEF00D);
    tick(); req_ren = '0; ramstate = FREE;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
